// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two valid/ready requesters.
// Each operation is accepted, executed and responded in three registered steps.
module alu_share_arbiter #(
  parameter int WORD_W    = 32,
  parameter int OP_W      = 4,
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WORD_W-1:0] req0_a,
  input  logic [WORD_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WORD_W-1:0] req1_a,
  input  logic [WORD_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WORD_W-1:0] rsp_data,
  output logic [2:0]        rsp_flags,
  output logic [WORD_W-1:0] alu_portA,
  output logic [WORD_W-1:0] alu_portB,
  output logic [OP_W-1:0]   alu_aluop,
  input  logic [WORD_W-1:0] alu_outPort,
  input  logic              alu_negative,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  output logic [CNT_W-1:0]  done_cnt0,
  output logic [CNT_W-1:0]  done_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state_q, state_d;
  logic   grant_sel;
  logic   accept;
  logic   drain;
  logic   last_grant;
  logic   owner_p0;

  // Arbitration: last_grant resets to 1 so requester 0 wins the first tie.
  always_comb begin
    grant_sel = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_sel = (PRIO_MODE != 0) ? 1'b0 : ~last_grant;
    end
    req0_ready = (state_q == IDLE) && req0_valid && !grant_sel;
    req1_ready = (state_q == IDLE) && req1_valid && grant_sel;
    accept     = req0_ready || req1_ready;
    drain      = (state_q == RESP) && rsp_valid && rsp_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (drain) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Stage p0: operands latched into the ALU input registers on accept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_portA  <= '0;
      alu_portB  <= '0;
      alu_aluop  <= '0;
      owner_p0   <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      alu_portA  <= grant_sel ? req1_a  : req0_a;
      alu_portB  <= grant_sel ? req1_b  : req0_b;
      alu_aluop  <= grant_sel ? req1_op : req0_op;
      owner_p0   <= grant_sel;
      last_grant <= grant_sel;
    end
  end

  // Stage p1: ALU result captured; held stable while the consumer stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_data  <= alu_outPort;
      rsp_flags <= {alu_negative, alu_overflow, alu_zero};
      rsp_id    <= owner_p0;
      rsp_valid <= 1'b1;
    end else if (drain) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else if (drain) begin
      if (rsp_id) done_cnt1 <= done_cnt1 + CNT_W'(1);
      else        done_cnt0 <= done_cnt0 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: round-robin instance (dut0) and fixed-priority 2-bit-counter
// instance (dut1) share stimulus; each drives its own behavioural ALU.
module tb_alu_share_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;

  logic        r0_rdy0, r1_rdy0, rv0, rid0, n0, o0, z0;
  logic [31:0] rd0, pa0, pb0, out0;
  logic [2:0]  rf0;
  logic [3:0]  op0;
  logic [15:0] c0_0, c1_0;

  logic        r0_rdy1, r1_rdy1, rv1, rid1, n1, o1, z1;
  logic [31:0] rd1, pa1, pb1, out1;
  logic [2:0]  rf1;
  logic [3:0]  op1;
  logic [1:0]  c0_1, c1_1;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt[5] = '{1, 2, 3, 0, 1};

  always #5 CLK = ~CLK;

  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [31:0] r;
    logic        ovf;
    r   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_AND: r = a & b;
      default: r = '0;
    endcase
    return {r, r[31], ovf, (r == 32'd0)};
  endfunction

  assign {out0, n0, o0, z0} = alu_model(pa0, pb0, op0);
  assign {out1, n1, o1, z1} = alu_model(pa1, pb1, op1);

  alu_share_arbiter #(.WORD_W(32), .OP_W(4), .PRIO_MODE(0), .CNT_W(16)) dut0 (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(r0_rdy0), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(r1_rdy0), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_id(rid0), .rsp_data(rd0), .rsp_flags(rf0),
    .alu_portA(pa0), .alu_portB(pb0), .alu_aluop(op0), .alu_outPort(out0),
    .alu_negative(n0), .alu_overflow(o0), .alu_zero(z0),
    .done_cnt0(c0_0), .done_cnt1(c1_0)
  );

  alu_share_arbiter #(.WORD_W(32), .OP_W(4), .PRIO_MODE(1), .CNT_W(2)) dut1 (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(r0_rdy1), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(r1_rdy1), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_id(rid1), .rsp_data(rd1), .rsp_flags(rf1),
    .alu_portA(pa1), .alu_portB(pb1), .alu_aluop(op1), .alu_outPort(out1),
    .alu_negative(n1), .alu_overflow(o1), .alu_zero(z1),
    .done_cnt0(c0_1), .done_cnt1(c1_1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_rsp_valid", rv0, 0);
    chk("rst_alu_portA", pa0, 0);
    chk("rst_done_cnt0", c0_0, 0);
    chk("rst_req0_ready", r0_rdy0, 0);
    do_reset();

    // Single ADD 5+7 from requester 0
    req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_ADD; req0_valid = 1'b1;
    #1;
    chk("t1_req0_ready", r0_rdy0, 1);
    chk("t1_req1_ready", r1_rdy0, 0);
    step();
    req0_valid = 1'b0;
    chk("t1_portA", pa0, 5);
    chk("t1_portB", pb0, 7);
    chk("t1_exec_rsp_valid", rv0, 0);
    chk("t1_exec_ready", r0_rdy0, 0);
    step();
    chk("t1_rsp_valid", rv0, 1);
    chk("t1_rsp_data", rd0, 12);
    chk("t1_rsp_id", rid0, 0);
    chk("t1_rsp_flags", rf0, 3'b000);
    step();
    chk("t1_drained", rv0, 0);
    chk("t1_done_cnt0", c0_0, 1);

    // Both valid continuously: dut0 alternates, dut1 serves only requester 0
    do_reset();
    req0_a = 32'd3; req0_b = 32'd3; req0_op = OP_SUB;
    req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_op = OP_ADD;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_req0_ready", r0_rdy0, (i % 2 == 0));
      chk("rr_req1_ready", r1_rdy0, (i % 2 == 1));
      chk("pr_req0_ready", r0_rdy1, 1);
      chk("pr_req1_ready", r1_rdy1, 0);
      step();
      chk("pr_req1_ready_exec", r1_rdy1, 0);
      step();
      chk("rr_rsp_valid", rv0, 1);
      chk("rr_rsp_id", rid0, (i % 2));
      chk("rr_rsp_data", rd0, (i % 2 == 0) ? 64'h0 : 64'h8000_0000);
      chk("rr_rsp_flags", rf0, (i % 2 == 0) ? 64'b001 : 64'b110);
      chk("pr_rsp_id", rid1, 0);
      chk("pr_rsp_data", rd1, 0);
      chk("pr_req1_ready_resp", r1_rdy1, 0);
      step();
    end
    chk("rr_done_cnt0", c0_0, 2);
    chk("rr_done_cnt1", c1_0, 2);
    chk("pr_done_cnt1", c1_1, 0);
    chk("pr_done_cnt0_wrap", c0_1, 0);

    // Backpressure: response held 5 cycles
    rsp_ready = 1'b0;
    chk("bp_accept_req0", r0_rdy0, 1);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rv0, 1);
      chk("bp_rsp_data", rd0, 0);
      chk("bp_rsp_flags", rf0, 3'b001);
      chk("bp_req0_ready", r0_rdy0, 0);
      chk("bp_req1_ready", r1_rdy0, 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rsp_data_held", rd0, 0);
    chk("bp_ready_before_hs", r1_rdy0, 0);
    step();
    chk("bp_drained", rv0, 0);
    chk("bp_done_cnt0", c0_0, 3);
    chk("bp_next_accept", r1_rdy0, 1);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("bp_rsp_id", rid0, 1);
    chk("bp_rsp_data2", rd0, 32'h8000_0000);
    step();
    chk("bp_done_cnt1", c1_0, 3);

    // Reset during EXEC of an AND
    req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_op = OP_AND; req0_valid = 1'b1;
    #1;
    chk("mr_req0_ready", r0_rdy0, 1);
    step();
    req0_valid = 1'b0;
    chk("mr_portA", pa0, 32'hF0F0_F0F0);
    chk("mr_aluop", op0, OP_AND);
    #2;
    RST = 1'b1;
    #1;
    chk("mr_portA_zero", pa0, 0);
    chk("mr_portB_zero", pb0, 0);
    chk("mr_aluop_zero", op0, 0);
    chk("mr_rsp_valid", rv0, 0);
    chk("mr_rsp_data", rd0, 0);
    chk("mr_rsp_flags", rf0, 0);
    chk("mr_rsp_id", rid0, 0);
    chk("mr_done_cnt0", c0_0, 0);
    chk("mr_done_cnt1", c1_0, 0);
    step();
    chk("mr_no_rsp", rv0, 0);
    RST = 1'b0;
    step();
    chk("mr_no_rsp_after", rv0, 0);
    req1_a = 32'd5; req1_b = 32'd7; req1_op = OP_ADD;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("mr_tie_req0", r0_rdy0, 1);
    chk("mr_tie_req1", r1_rdy0, 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("mr_rsp_id2", rid0, 0);
    chk("mr_rsp_data2", rd0, 32'hF000_F000);
    chk("mr_rsp_flags2", rf0, 3'b100);
    step();
    chk("mr_done_cnt0b", c0_0, 1);

    // Counter wrap with CNT_W=2 on requester 1
    req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("wr_req1_ready", r1_rdy1, 1);
      step();
      step();
      chk("wr_rsp_data", rd1, 12);
      chk("wr_rsp_id", rid1, 1);
      step();
      chk("wr_done_cnt1", c1_1, exp_cnt[i]);
      chk("rr16_done_cnt1", c1_0, i + 1);
    end
    req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (the alu_if datapath: portA, portB, aluop, outPort, negative, overflow, zero) between two requesters.
- Uses a valid/ready request handshake and a single buffered response channel.
- Sequences each operation as accept, then execute, then respond, with every ALU input and output registered.
- Sits between the issue logic (or the board-level test wrapper) and the alu instance; also keeps per-requester completion counters for debug display.

Parameters:
- WORD_W, 32, operand/result width (matches word_t).
- OP_W, 4, aluop_t width.
- PRIO_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 0 always wins.
- CNT_W, 16, width of each completion counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a  in  WORD_W  requester 0 operand A.
- req0_b  in  WORD_W  requester 0 operand B.
- req0_op  in  OP_W  requester 0 aluop.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  WORD_W  registered ALU outPort.
- rsp_flags  out  3  registered {negative, overflow, zero}.
- alu_portA  out  WORD_W  to ALU portA.
- alu_portB  out  WORD_W  to ALU portB.
- alu_aluop  out  OP_W  to ALU aluop.
- alu_outPort  in  WORD_W  from ALU.
- alu_negative, alu_overflow, alu_zero  in  1 each  ALU flags.
- done_cnt0  out  CNT_W  responses delivered to requester 0.
- done_cnt1  out  CNT_W  responses delivered to requester 1.

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset values:
  - state = IDLE.
  - All outputs 0: alu_portA/B, alu_aluop, rsp_data, rsp_flags, rsp_id, rsp_valid, both done_cnt.
  - last_grant = 1, so requester 0 wins the first tie.
- IDLE, arbitration (combinational):
  - Only one valid: grant that requester.
  - Both valid, PRIO_MODE=0: grant the requester that is not last_grant.
  - Both valid, PRIO_MODE=1: grant requester 0.
  - reqN_ready = (state==IDLE) & grantN. Ready depends combinationally on valid. Ready is never asserted outside IDLE.
- IDLE, on a handshake edge:
  - Latch a, b, op into alu_portA/B/aluop.
  - Record the grant as owner and last_grant.
  - Go to EXEC.
  - No request: stay in IDLE; ALU output registers hold their values.
- EXEC (exactly one cycle):
  - Capture alu_outPort into rsp_data and the flags into rsp_flags.
  - Set rsp_id = owner and rsp_valid = 1.
  - Go to RESP.
- RESP:
  - rsp_valid = 1 and rsp_data/flags/id are held stable until rsp_valid & rsp_ready.
  - On that edge: clear rsp_valid, increment done_cnt[rsp_id], go to IDLE.
- Latency and throughput:
  - Accept edge at cycle k; rsp_valid is high from cycle k+2.
  - With rsp_ready tied high, the response drains at the end of cycle k+2.
  - Maximum throughput is one operation per 3 cycles.
- A requester that drops valid before ready is not served; nothing is latched.
- Counters wrap modulo 2^CNT_W with no saturation.
- Simultaneous events:
  - A request arriving while in RESP waits; it is arbitrated in the following IDLE cycle.
  - Round-robin guarantees neither requester waits more than one other operation when both stay valid.
- Reset mid-operation (EXEC or RESP):
  - The in-flight operation is dropped and no response is produced.
  - All registers and counters return to reset values immediately (asynchronous).
- Arithmetic is entirely inside the ALU. This block never modifies operands, results or flags.

Test Plan:
- Reset, then req0 only: req0 = ADD, a=5, b=7. Required: req0_ready high in the accept cycle; rsp_valid two cycles later with rsp_data=12, rsp_id=0, rsp_flags=000; done_cnt0=1 after the handshake.
- Both requesters valid continuously, PRIO_MODE=0: req0 = SUB 3-3, req1 = ADD 0x7FFFFFFF+1. Required: grants alternate 0,1,0,…; responses are id 0 with data=0 and zero flag set, then id 1 with data=0x80000000 and negative and overflow set.
- Same stimulus with PRIO_MODE=1: only requester 0 is served; req1_ready never asserts while req0_valid stays high.
- Backpressure: hold rsp_ready low 5 cycles after rsp_valid. Required: rsp_data and rsp_flags stable; req0_ready/req1_ready stay low; the next accept comes the cycle after the rsp handshake.
- Assert RST during EXEC of an AND 0xF0F0F0F0 & 0xFF00FF00 operation. Required: no rsp_valid pulse; all outputs 0; the next request completes normally with id 0 winning the tie.
- CNT_W=2: perform 5 req1 operations. Required: done_cnt1 sequence 1,2,3,0,1.
